// File: rtl/multi_inputconditioner.sv
// multi_inputconditioner
// Per-channel input conditioning for asynchronous, possibly bouncing inputs:
// a 2-flop synchronizer, a counter-based debouncer, registered edge pulses,
// a combined any-edge pulse and a sticky flag for rejected short pulses.
// Channels are fully independent. The only coupling between them is the
// shared glitch clear and the OR that forms anyedge.

module multi_inputconditioner #(
    parameter int CHANNELS     = 4,
    parameter int COUNTERWIDTH = 3,
    parameter int WAITTIME     = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisysignal,
    input  logic                glitchclear,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic                anyedge,
    output logic [CHANNELS-1:0] glitch
);

    // Terminal count of the debounce counter, sized to the counter.
    localparam logic [COUNTERWIDTH-1:0] WAIT_C = COUNTERWIDTH'(WAITTIME);
    localparam logic [COUNTERWIDTH-1:0] ZERO_C = {COUNTERWIDTH{1'b0}};
    localparam logic [COUNTERWIDTH-1:0] ONE_C  = COUNTERWIDTH'(1);

    // Synchronizer stages.
    logic [CHANNELS-1:0]     sync0_r;
    logic [CHANNELS-1:0]     sync1_r;

    // Debounce state and registered outputs.
    logic [COUNTERWIDTH-1:0] cnt_r [CHANNELS];
    logic [CHANNELS-1:0]     cond_r;
    logic [CHANNELS-1:0]     pos_r;
    logic [CHANNELS-1:0]     neg_r;
    logic                    any_r;
    logic [CHANNELS-1:0]     glitch_r;

    // Next-state values.
    logic [COUNTERWIDTH-1:0] cnt_nxt_s [CHANNELS];
    logic [CHANNELS-1:0]     cond_nxt_s;
    logic [CHANNELS-1:0]     pos_nxt_s;
    logic [CHANNELS-1:0]     neg_nxt_s;
    logic [CHANNELS-1:0]     glitch_set_s;
    logic [CHANNELS-1:0]     glitch_nxt_s;

    // Debounce decision, edge detection and glitch flag update for every channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt_s[i]    = cnt_r[i];
            cond_nxt_s[i]   = cond_r[i];
            glitch_set_s[i] = 1'b0;
            if (sync1_r[i] == cond_r[i]) begin
                // Input agrees with the output: any run in progress was a bounce.
                cnt_nxt_s[i]    = ZERO_C;
                glitch_set_s[i] = (cnt_r[i] != ZERO_C);
            end else if (cnt_r[i] == WAIT_C) begin
                // Input differed for the whole window: accept the new level.
                cond_nxt_s[i] = sync1_r[i];
                cnt_nxt_s[i]  = ZERO_C;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + ONE_C;
            end
            pos_nxt_s[i] = cond_nxt_s[i] & ~cond_r[i];
            neg_nxt_s[i] = ~cond_nxt_s[i] & cond_r[i];
            // A newly detected glitch takes priority over the clear.
            if (glitchclear) begin
                glitch_nxt_s[i] = glitch_set_s[i];
            end else begin
                glitch_nxt_s[i] = glitch_r[i] | glitch_set_s[i];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync0_r  <= {CHANNELS{1'b0}};
            sync1_r  <= {CHANNELS{1'b0}};
            cond_r   <= {CHANNELS{1'b0}};
            pos_r    <= {CHANNELS{1'b0}};
            neg_r    <= {CHANNELS{1'b0}};
            any_r    <= 1'b0;
            glitch_r <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= ZERO_C;
            end
        end else begin
            sync0_r  <= noisysignal;
            sync1_r  <= sync0_r;
            cond_r   <= cond_nxt_s;
            pos_r    <= pos_nxt_s;
            neg_r    <= neg_nxt_s;
            any_r    <= |(pos_nxt_s | neg_nxt_s);
            glitch_r <= glitch_nxt_s;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign conditioned  = cond_r;
    assign positiveedge = pos_r;
    assign negativeedge = neg_r;
    assign anyedge      = any_r;
    assign glitch       = glitch_r;

endmodule

// File: tb/tb_multi_inputconditioner.sv
// Directed self-checking bench for multi_inputconditioner: a default
// instance (4 channels, WAITTIME=3) and a 1-channel WAITTIME=0 instance.

module tb_multi_inputconditioner;

    logic       clk;
    logic       reset_n;
    logic [3:0] noisy;
    logic       gclr;
    logic [3:0] cond;
    logic [3:0] pos;
    logic [3:0] neg;
    logic       any;
    logic [3:0] glt;

    logic [0:0] noisy1;
    logic [0:0] cond1;
    logic [0:0] pos1;
    logic [0:0] neg1;
    logic       any1;
    logic [0:0] glt1;

    int n_total;
    int n_bad;

    multi_inputconditioner u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .noisysignal  (noisy),
        .glitchclear  (gclr),
        .conditioned  (cond),
        .positiveedge (pos),
        .negativeedge (neg),
        .anyedge      (any),
        .glitch       (glt)
    );

    multi_inputconditioner #(
        .CHANNELS     (1),
        .COUNTERWIDTH (3),
        .WAITTIME     (0)
    ) u_dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .noisysignal  (noisy1),
        .glitchclear  (gclr),
        .conditioned  (cond1),
        .positiveedge (pos1),
        .negativeedge (neg1),
        .anyedge      (any1),
        .glitch       (glt1)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 after the edge.
    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        noisy   = 4'b0000;
        noisy1  = 1'b0;
        gclr    = 1'b0;

        // Reset state.
        tick(2);
        chk("rst_cond", 32'(cond), 32'h0);
        chk("rst_edges", 32'({pos, neg, any}), 32'h0);
        chk("rst_glitch", 32'(glt), 32'h0);
        reset_n = 1'b1;
        tick(3);

        // ch0 rises, sampled at edge k; conditioned at k+5.
        noisy = 4'b0001;
        tick(5);
        chk("rise0_k4_cond", 32'(cond), 32'h0);
        tick(1);
        chk("rise0_k5_cond", 32'(cond), 32'h1);
        chk("rise0_k5_pos", 32'(pos), 32'h1);
        chk("rise0_k5_any", 32'(any), 32'h1);
        chk("rise0_k5_neg", 32'(neg), 32'h0);
        tick(1);
        chk("rise0_k6_pos", 32'(pos), 32'h0);
        chk("rise0_k6_any", 32'(any), 32'h0);
        chk("rise0_k6_cond", 32'(cond), 32'h1);

        // ch1 high for 2 cycles: rejected, glitch set at k+4.
        noisy = 4'b0011;
        tick(2);
        noisy = 4'b0001;
        tick(2);
        chk("glt1_k3", 32'(glt), 32'h0);
        tick(1);
        chk("glt1_k4", 32'(glt), 32'h2);
        for (int j = 0; j < 4; j++) begin
            chk("glt1_noedge", 32'({pos, neg, any}), 32'h0);
            chk("glt1_cond", 32'(cond), 32'h1);
            tick(1);
        end
        chk("glt1_sticky", 32'(glt), 32'h2);
        gclr = 1'b1;
        tick(1);
        gclr = 1'b0;
        chk("glt1_clear", 32'(glt), 32'h0);

        // ch0 falls: negative edge at k+5.
        noisy = 4'b0000;
        tick(5);
        chk("fall0_k4_cond", 32'(cond), 32'h1);
        tick(1);
        chk("fall0_k5_neg", 32'(neg), 32'h1);
        chk("fall0_k5_any", 32'(any), 32'h1);
        chk("fall0_k5_pos", 32'(pos), 32'h0);
        chk("fall0_k5_cond", 32'(cond), 32'h0);
        tick(2);

        // ch0 and ch3 rise together: one shared anyedge pulse.
        noisy = 4'b1001;
        tick(5);
        chk("dual_k4_pos", 32'(pos), 32'h0);
        tick(1);
        chk("dual_k5_pos", 32'(pos), 32'h9);
        chk("dual_k5_any", 32'(any), 32'h1);
        tick(1);
        chk("dual_k6_any", 32'(any), 32'h0);
        chk("dual_k6_cond", 32'(cond), 32'h9);

        // ch2 up, then falls and reset hits two edges later.
        noisy = 4'b1101;
        tick(6);
        chk("ch2_up_cond", 32'(cond), 32'hD);
        noisy = 4'b1001;
        tick(2);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("rst2_cond", 32'(cond), 32'h0);
        chk("rst2_edges", 32'({pos, neg, any}), 32'h0);
        chk("rst2_glitch", 32'(glt), 32'h0);
        // Inputs held high through release: rise WAITTIME+3 edges after reset edge.
        for (int j = 0; j < 5; j++) begin
            tick(1);
            chk("rel_noedge", 32'({pos, neg, any}), 32'h0);
            chk("rel_cond", 32'(cond), 32'h0);
        end
        tick(1);
        chk("rel_k6_cond", 32'(cond), 32'h9);
        chk("rel_k6_pos", 32'(pos), 32'h9);
        chk("rel_k6_any", 32'(any), 32'h1);
        tick(2);

        // Glitch on ch2, then a ch1 glitch coinciding with a clear.
        noisy = 4'b1101;
        tick(1);
        noisy = 4'b1001;
        tick(3);
        chk("glt2_set", 32'(glt), 32'h4);
        noisy = 4'b1011;
        tick(1);
        noisy = 4'b1001;
        tick(2);
        chk("glt_pre_clr", 32'(glt), 32'h4);
        gclr = 1'b1;
        tick(1);
        gclr = 1'b0;
        chk("glt_set_wins", 32'(glt), 32'h2);
        chk("glt_cond", 32'(cond), 32'h9);
        gclr = 1'b1;
        tick(1);
        gclr = 1'b0;
        chk("glt_clear2", 32'(glt), 32'h0);

        // WAITTIME=0 instance: step at edge k visible at k+2.
        noisy1 = 1'b1;
        tick(2);
        chk("w0_k1_cond", 32'(cond1), 32'h0);
        tick(1);
        chk("w0_k2_cond", 32'(cond1), 32'h1);
        chk("w0_k2_pos", 32'(pos1), 32'h1);
        chk("w0_k2_any", 32'(any1), 32'h1);
        tick(1);
        chk("w0_k3_pos", 32'(pos1), 32'h0);
        noisy1 = 1'b0;
        tick(3);
        chk("w0_fall_neg", 32'(neg1), 32'h1);
        chk("w0_fall_cond", 32'(cond1), 32'h0);
        // A single-cycle pulse passes straight through with no glitch.
        noisy1 = 1'b1;
        tick(1);
        noisy1 = 1'b0;
        tick(2);
        chk("w0_pulse_cond", 32'(cond1), 32'h1);
        tick(1);
        chk("w0_pulse_back", 32'(cond1), 32'h0);
        chk("w0_noglitch", 32'(glt1), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_inputconditioner.md
MULTI_INPUTCONDITIONER -- requirements
Module: multi_inputconditioner

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels (>=1).
REQ-002 SHALL have parameter COUNTERWIDTH, default 3, debounce counter width in bits.
REQ-003 SHALL have parameter WAITTIME, default 3, debounce delay in clock cycles, 0 <= WAITTIME <= 2^COUNTERWIDTH-1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port noisysignal  input  CHANNELS  asynchronous, possibly bouncing inputs, bit i = channel i.
REQ-007 SHALL have port glitchclear  input  1  synchronous clear of all glitch flags.
REQ-008 SHALL have port conditioned  output  CHANNELS  synchronized, debounced level per channel.
REQ-009 SHALL have port positiveedge  output  CHANNELS  1-cycle pulse when conditioned[i] goes 0->1.
REQ-010 SHALL have port negativeedge  output  CHANNELS  1-cycle pulse when conditioned[i] goes 1->0.
REQ-011 SHALL have port anyedge  output  1  1-cycle pulse when any channel produces a positive or negative edge.
REQ-012 SHALL have port glitch  output  CHANNELS  sticky flag: channel i rejected a pulse shorter than the debounce window.

Function
REQ-013 SHALL pass each noisysignal[i] through a dedicated 2-flop synchronizer (sync0 <= noisysignal, sync1 <= sync0) before any other use.
REQ-014 SHALL keep one COUNTERWIDTH-bit counter per channel, with channels fully independent.
REQ-015 SHALL, per channel, each cycle: if sync1 == conditioned -> counter <= 0; else if counter == WAITTIME -> conditioned <= sync1, counter <= 0; else counter <= counter+1.
REQ-016 SHALL make a level stable at noisysignal[i] from sampling edge k visible on conditioned[i] after edge k+WAITTIME+2 (WAITTIME=3: change at edge k+5).
REQ-017 SHALL assert positiveedge[i] for exactly one cycle, registered in the same cycle conditioned[i] becomes 1; negativeedge[i] likewise when it becomes 0.
REQ-018 SHALL never assert positiveedge[i] and negativeedge[i] in the same cycle.
REQ-019 SHALL drive anyedge as a registered OR of all positiveedge and negativeedge bits, coincident with them; simultaneous edges on several channels give one anyedge pulse.
REQ-020 SHALL set glitch[i] on any cycle where counter[i] != 0 and sync1[i] == conditioned[i], i.e. a debounce run aborted.
REQ-021 SHALL clear all glitch bits on a cycle with glitchclear=1; a simultaneous set on a channel wins over clear for that channel.
REQ-022 SHALL restart the debounce count from 0 after an aborted run; a bounce never produces partial output changes.
REQ-023 SHALL, when WAITTIME=0, update conditioned on the first cycle sync1 differs from it (latency edge k+2), with no glitch possible.
REQ-024 SHALL never let the counter exceed WAITTIME or wrap.

Reset
REQ-025 SHALL, on posedge clk with reset_n=0, clear all synchronizer flops, counters, conditioned, positiveedge, negativeedge, anyedge and glitch to 0.
REQ-026 SHALL abort any in-progress debounce on reset without emitting an edge pulse.
REQ-027 SHALL treat an input held at 1 through reset release as a normal 0->1 transition: conditioned and positiveedge assert WAITTIME+3 edges after release.

Verification
REQ-028 Defaults; ch0 steps 0->1 at edge 10 and holds -> conditioned[0]=1 and positiveedge[0]=anyedge=1 for one cycle at edge 15; other channels stay 0.
REQ-029 ch1 high for 2 cycles then low (WAITTIME=3) -> conditioned[1] stays 0, no edge pulses, glitch[1]=1 until glitchclear pulse, then 0.
REQ-030 ch0 and ch3 rise at the same edge -> both positiveedge bits at the same cycle, single anyedge pulse.
REQ-031 ch2 conditioned=1, input falls, reset_n=0 for one cycle two edges later -> all outputs 0, no negativeedge pulse emitted.
REQ-032 glitchclear=1 on the same cycle a new glitch is detected on ch1 -> glitch[1]=1 afterwards, other glitch bits cleared.
REQ-033 WAITTIME=0, CHANNELS=1 -> input step at edge k gives conditioned and positiveedge at edge k+2.
